if_pc_unit: RTL and testbench
=============================

# if_pc_unit

Program-counter and fetch-sequencing unit for the single-issue MIPS core. It consumes the one-hot PC-source select and related enables produced by instruction decode, holds the PC and the jump-register temp value, and sequences delay-slot fetch and branch redirects. It drives the instruction RAM address and enable every cycle. It sits at the front of the pipeline, between decode feedback and the instruction RAM.

## Interface
- RESET_PC, 32'hBFC0_0000: PC value loaded on reset.
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- stall  in  1  freeze: PC, state and temp hold; no fetch
- ctl_pcValue_mux  in  5  one-hot PC source, bit order [0]=PC+4, [1]=aluRes, [2]=instIndex, [3]=temp, [4]=useDelaySlot
- ctl_temp_wen  in  1  load temp register (JR/JALR target)
- temp_wdata  in  32  value loaded into temp (rs read data)
- alu_res  in  32  computed branch target
- inst_index  in  26  J/JAL index field
- pc  out  32  current fetch PC
- pc_plus8  out  32  pc + 8, link value for JAL/JALR/BxxAL
- inst_ram_en  out  1  instruction RAM read enable
- inst_ram_addr  out  32  equals pc
- in_slot  out  1  current fetch is a delay slot
- sel_err  out  1  one-cycle pulse on illegal select

## Operation
- States: RUN (sequential fetch), SLOT (delay slot in flight, redirect pending).
- Select decode: bits resolved by priority [4]>[3]>[2]>[1]>[0]. Zero bits or more than one bit set: sel_err=1 that cycle, highest set bit wins. All-zero is treated as PC+4.
- RUN, sel PC+4: pc <= pc+4, stay RUN.
- RUN, sel useDelaySlot: pc <= pc+4 (delay slot). Go to SLOT. Record slot_pc = pc+4.
- RUN, sel aluRes/instIndex/temp without a prior useDelaySlot: illegal. sel_err=1, pc <= pc+4, stay RUN.
- SLOT, sel aluRes: pc <= alu_res, go RUN.
- SLOT, sel instIndex: pc <= {slot_pc[31:28], inst_index, 2'b00}, go RUN.
- SLOT, sel temp: pc <= temp, go RUN. If ctl_temp_wen is asserted in the same cycle, temp_wdata is used (bypass).
- SLOT, sel PC+4 (branch not taken): pc <= pc+4, go RUN.
- SLOT, sel useDelaySlot (branch in delay slot): sel_err=1, handled as not-taken, go RUN.
- Temp register: loads temp_wdata whenever ctl_temp_wen=1 and stall=0, in any state.
- Arithmetic: 32-bit, wraps modulo 2^32 (32'hFFFF_FFFC + 4 = 0). No alignment check; pc[1:0] passes through from alu_res/temp unchanged.
- in_slot = (state == SLOT).

## Timing
- Reset (rst=1 at an edge) gives: pc=RESET_PC, state RUN, temp=0, slot_pc=0. Outputs: inst_ram_en=0, sel_err=0, in_slot=0, pc_plus8=RESET_PC+8.
- Reset has priority over stall and all selects. A reset in SLOT abandons the pending redirect.
- inst_ram_en = ~rst_q & ~stall, where rst_q is a register set by reset and cleared on the first non-reset edge. The first fetch after reset is therefore RESET_PC, one cycle after rst falls.
- Registered PC. Select sampled at edge n gives the new pc visible after edge n.
- Branch at A: pc=A at cycle n with useDelaySlot; pc=A+4 at n+1 (in_slot=1); target resolved at n+1; pc=target at n+2.
- stall=1: all registers hold, selects and ctl_temp_wen ignored, sel_err=0, inst_ram_en=0. SLOT persists across stalls.
- pc, pc_plus8, inst_ram_addr, in_slot are combinational from registers. sel_err is combinational from the inputs, gated by ~stall & ~rst.

## Test plan
- Reset/sequential: hold rst 2 cycles, release, drive sel=5'b00001 for 3 cycles -> pc sequence BFC00000, BFC00004, BFC00008, BFC0000C; inst_ram_en 0 during reset and 1 after; pc_plus8=BFC00008 at first fetch.
- J via delay slot: at pc=BFC00010 drive sel=10000, then sel=00100 with inst_index=26'h0000040 -> pc=BFC00014 with in_slot=1, then pc=B0000100, in_slot=0.
- JR with temp bypass: sel=10000, then sel=01000 with ctl_temp_wen=1 and temp_wdata=8000_0020 in the same cycle -> pc=8000_0020.
- Branch not taken plus stall: sel=10000, then stall=1 for 3 cycles, then sel=00001 -> pc frozen at slot address with in_slot=1 and inst_ram_en=0 during the stall, then pc=slot+4.
- Errors: sel=00110 in RUN -> sel_err=1, pc advances by +4 (instIndex is illegal in RUN). sel=10000 in SLOT -> sel_err=1, not-taken.
- Reset mid-SLOT and wrap: assert rst while in_slot=1 -> pc=RESET_PC, in_slot=0. Then branch with alu_res=FFFFFFFC, then sel=00001 -> pc=00000000.

Source files
------------

// File: rtl/if_pc_unit.sv
// -----------------------------------------------------------------------------
// if_pc_unit
//
// Program-counter and fetch-sequencing unit for the single-issue MIPS core.
// Holds the PC, the jump-register temp value and the delay-slot PC. It turns
// the one-hot PC-source select from decode into the next fetch address. It
// also sequences the delay-slot fetch that comes before every redirect.
//
// Ports
//   clk            in   1   system clock, rising edge
//   rst            in   1   synchronous, active-high reset
//   stall          in   1   freeze all state, suppress fetch and sel_err
//   ctl_pcValue_mux in  5   one-hot PC source:
//                           [0]=PC+4 [1]=aluRes [2]=instIndex [3]=temp
//                           [4]=useDelaySlot
//   ctl_temp_wen   in   1   load temp register (JR/JALR target)
//   temp_wdata     in  32   value loaded into temp
//   alu_res        in  32   computed branch target
//   inst_index     in  26   J/JAL index field
//   pc             out 32   current fetch PC
//   pc_plus8       out 32   pc + 8, link value
//   inst_ram_en    out  1   instruction RAM read enable
//   inst_ram_addr  out 32   instruction RAM address (equals pc)
//   in_slot        out  1   current fetch is a delay slot
//   sel_err        out  1   illegal select this cycle
//   state_dbg      out  1   FSM state (0=RUN, 1=SLOT)
//
// Fetch handshake: inst_ram_en acts as the fetch valid. The instruction RAM
// is always ready. A fetch of inst_ram_addr happens in every cycle where
// inst_ram_en=1, and the PC advances only at an edge that closes such a
// cycle. When inst_ram_en=0, the PC, FSM state and slot PC hold.
// -----------------------------------------------------------------------------
module if_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic [4:0]  ctl_pcValue_mux,
    input  logic        ctl_temp_wen,
    input  logic [31:0] temp_wdata,
    input  logic [31:0] alu_res,
    input  logic [25:0] inst_index,
    output logic [31:0] pc,
    output logic [31:0] pc_plus8,
    output logic        inst_ram_en,
    output logic [31:0] inst_ram_addr,
    output logic        in_slot,
    output logic        sel_err,
    output logic        state_dbg
);

    typedef enum logic {
        RUN  = 1'b0,
        SLOT = 1'b1
    } state_t;

    typedef enum logic [2:0] {
        SRC_PC4,
        SRC_ALU,
        SRC_IDX,
        SRC_TEMP,
        SRC_DS
    } src_t;

    state_t      state_q, state_next;
    logic [31:0] pc_q, pc_next;
    logic [31:0] temp_q;
    logic [31:0] slot_pc_q, slot_pc_next;
    logic        rst_q;

    src_t        src;
    logic        sel_bad;     // zero bits or more than one bit set
    logic        ctx_bad;     // legal one-hot, but not allowed in this state
    logic        fetch;
    logic [31:0] pc_inc;

    assign pc_inc = pc_q + 32'd4;
    // No fetch in the first cycle after reset, so the PC must not advance
    // at the edge that ends that cycle. RESET_PC is the first fetched address.
    assign fetch  = ~rst_q & ~stall;

    // Priority decode: the highest set bit wins, and all-zero means PC+4.
    always_comb begin
        src = SRC_PC4;
        if (ctl_pcValue_mux[4])      src = SRC_DS;
        else if (ctl_pcValue_mux[3]) src = SRC_TEMP;
        else if (ctl_pcValue_mux[2]) src = SRC_IDX;
        else if (ctl_pcValue_mux[1]) src = SRC_ALU;
    end

    always_comb begin
        sel_bad = (ctl_pcValue_mux == 5'b00000) ||
                  ((ctl_pcValue_mux & (ctl_pcValue_mux - 5'd1)) != 5'b00000);
    end

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RUN;
            pc_q      <= RESET_PC;
            temp_q    <= 32'h0;
            slot_pc_q <= 32'h0;
            rst_q     <= 1'b1;
        end else begin
            rst_q     <= 1'b0;
            state_q   <= state_next;
            pc_q      <= pc_next;
            slot_pc_q <= slot_pc_next;
            // Temp loads in any state. Only a stall blocks it.
            if (ctl_temp_wen && !stall) begin
                temp_q <= temp_wdata;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Next-state / next-PC logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next   = state_q;
        pc_next      = pc_q;
        slot_pc_next = slot_pc_q;
        if (fetch) begin
            case (state_q)
                RUN: begin
                    // Redirect selects are illegal here and fall back to +4.
                    pc_next = pc_inc;
                    if (src == SRC_DS) begin
                        state_next   = SLOT;
                        slot_pc_next = pc_inc;
                    end
                end
                SLOT: begin
                    state_next = RUN;
                    case (src)
                        SRC_ALU:  pc_next = alu_res;
                        SRC_IDX:  pc_next = {slot_pc_q[31:28], inst_index, 2'b00};
                        // Bypass a temp write in the same cycle, so JR can
                        // resolve without waiting one cycle for the temp register.
                        SRC_TEMP: pc_next = ctl_temp_wen ? temp_wdata : temp_q;
                        // PC+4 is branch not taken. A branch in the delay
                        // slot is flagged and handled as not taken.
                        default:  pc_next = pc_inc;
                    endcase
                end
                default: begin
                    state_next = RUN;
                    pc_next    = pc_inc;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    always_comb begin
        ctx_bad = 1'b0;
        if (state_q == RUN) begin
            ctx_bad = (src == SRC_ALU) || (src == SRC_IDX) || (src == SRC_TEMP);
        end else begin
            ctx_bad = (src == SRC_DS);
        end
        sel_err       = ~stall & ~rst & (sel_bad | ctx_bad);
        inst_ram_en   = ~rst_q & ~stall;
        in_slot       = (state_q == SLOT);
        state_dbg     = state_q;
        pc            = pc_q;
        pc_plus8      = pc_q + 32'd8;
        inst_ram_addr = pc_q;
    end

endmodule

// File: tb/tb_if_pc_unit.sv
// -----------------------------------------------------------------------------
// tb_if_pc_unit
//
// Directed bench for if_pc_unit. Inputs change 1ns after a rising edge.
// Outputs are read in the same window, away from the active edge.
// -----------------------------------------------------------------------------
module tb_if_pc_unit;

    localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

    logic        clk;
    logic        rst;
    logic        stall;
    logic [4:0]  sel;
    logic        temp_wen;
    logic [31:0] temp_wdata;
    logic [31:0] alu_res;
    logic [25:0] inst_index;
    logic [31:0] pc;
    logic [31:0] pc_plus8;
    logic        inst_ram_en;
    logic [31:0] inst_ram_addr;
    logic        in_slot;
    logic        sel_err;
    logic        state_dbg;

    int tests_run;
    int tests_failed;

    if_pc_unit #(.RESET_PC(RESET_PC)) dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .ctl_pcValue_mux (sel),
        .ctl_temp_wen    (temp_wen),
        .temp_wdata      (temp_wdata),
        .alu_res         (alu_res),
        .inst_index      (inst_index),
        .pc              (pc),
        .pc_plus8        (pc_plus8),
        .inst_ram_en     (inst_ram_en),
        .inst_ram_addr   (inst_ram_addr),
        .in_slot         (in_slot),
        .sel_err         (sel_err),
        .state_dbg       (state_dbg)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Advance one rising edge, then settle 1ns into the cycle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Check pc, in_slot and the derived outputs in one call.
    task automatic check_pc(input string tag, input logic [31:0] exp_pc, input logic exp_slot);
        check({tag, ".pc"}, pc, exp_pc);
        check({tag, ".addr"}, inst_ram_addr, exp_pc);
        check({tag, ".pc8"}, pc_plus8, exp_pc + 32'd8);
        check({tag, ".slot"}, {31'h0, in_slot}, {31'h0, exp_slot});
        check({tag, ".dbg"}, {31'h0, state_dbg}, {31'h0, exp_slot});
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst        = 1'b1;
        stall      = 1'b0;
        sel        = 5'b00001;
        temp_wen   = 1'b0;
        temp_wdata = 32'h0;
        alu_res    = 32'h0;
        inst_index = 26'h0;

        // Reset / sequential fetch
        step();
        step();
        check_pc("rst", RESET_PC, 1'b0);
        check("rst.en", {31'h0, inst_ram_en}, 32'h0);
        check("rst.err", {31'h0, sel_err}, 32'h0);
        rst = 1'b0;
        #1;
        check("post_rst.en", {31'h0, inst_ram_en}, 32'h0);
        step();
        check_pc("fetch0", 32'hBFC0_0000, 1'b0);
        check("fetch0.en", {31'h0, inst_ram_en}, 32'h1);
        check("fetch0.pc8", pc_plus8, 32'hBFC0_0008);
        step();
        check_pc("seq1", 32'hBFC0_0004, 1'b0);
        step();
        check_pc("seq2", 32'hBFC0_0008, 1'b0);
        step();
        check_pc("seq3", 32'hBFC0_000C, 1'b0);
        step();
        check_pc("seq4", 32'hBFC0_0010, 1'b0);

        // J via delay slot
        sel = 5'b10000;
        #1;
        check("j.ds_err", {31'h0, sel_err}, 32'h0);
        step();
        check_pc("j.slot", 32'hBFC0_0014, 1'b1);
        sel        = 5'b00100;
        inst_index = 26'h0000040;
        #1;
        check("j.err", {31'h0, sel_err}, 32'h0);
        step();
        check_pc("j.target", 32'hB000_0100, 1'b0);

        // JR with temp bypass
        sel = 5'b10000;
        step();
        check_pc("jr.slot", 32'hB000_0104, 1'b1);
        sel        = 5'b01000;
        temp_wen   = 1'b1;
        temp_wdata = 32'h8000_0020;
        step();
        check_pc("jr.bypass", 32'h8000_0020, 1'b0);

        // JR from the registered temp value
        temp_wen   = 1'b0;
        temp_wdata = 32'h1234_5678;
        sel        = 5'b10000;
        step();
        check_pc("jr2.slot", 32'h8000_0024, 1'b1);
        sel = 5'b01000;
        step();
        check_pc("jr2.reg", 32'h8000_0020, 1'b0);

        // Branch not taken with stall in the slot
        sel = 5'b10000;
        step();
        check_pc("nt.slot", 32'h8000_0024, 1'b1);
        stall    = 1'b1;
        sel      = 5'b00110;
        temp_wen = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall.en", {31'h0, inst_ram_en}, 32'h0);
            check("stall.err", {31'h0, sel_err}, 32'h0);
            step();
            check_pc("stall.hold", 32'h8000_0024, 1'b1);
        end
        stall    = 1'b0;
        temp_wen = 1'b0;
        sel      = 5'b00001;
        #1;
        check("nt.en", {31'h0, inst_ram_en}, 32'h1);
        step();
        check_pc("nt.next", 32'h8000_0028, 1'b0);

        // The temp write during stall must not have taken effect
        sel = 5'b10000;
        step();
        check_pc("tchk.slot", 32'h8000_002C, 1'b1);
        sel = 5'b01000;
        step();
        check_pc("tchk.target", 32'h8000_0020, 1'b0);

        // Illegal selects
        sel = 5'b00110;
        #1;
        check("err.run_idx", {31'h0, sel_err}, 32'h1);
        step();
        check_pc("err.run_pc", 32'h8000_0024, 1'b0);
        sel = 5'b00000;
        #1;
        check("err.zero", {31'h0, sel_err}, 32'h1);
        step();
        check_pc("err.zero_pc", 32'h8000_0028, 1'b0);
        sel = 5'b10000;
        step();
        check_pc("err.slot", 32'h8000_002C, 1'b1);
        #1;
        check("err.ds_in_slot", {31'h0, sel_err}, 32'h1);
        step();
        check_pc("err.nt", 32'h8000_0030, 1'b0);
        sel = 5'b00010;
        #1;
        check("err.run_alu", {31'h0, sel_err}, 32'h1);
        step();
        check_pc("err.alu_pc", 32'h8000_0034, 1'b0);

        // Reset mid-SLOT
        sel     = 5'b10000;
        step();
        check_pc("rs.slot", 32'h8000_0038, 1'b1);
        sel     = 5'b00010;
        alu_res = 32'h1111_1110;
        rst     = 1'b1;
        #1;
        check("rs.err", {31'h0, sel_err}, 32'h0);
        step();
        check_pc("rs.reset", RESET_PC, 1'b0);
        check("rs.en", {31'h0, inst_ram_en}, 32'h0);
        rst = 1'b0;
        sel = 5'b10000;
        step();
        check_pc("rs.hold", RESET_PC, 1'b0);

        // Wrap around 2^32
        step();
        check_pc("wrap.slot", 32'hBFC0_0004, 1'b1);
        sel     = 5'b00010;
        alu_res = 32'hFFFF_FFFC;
        step();
        check_pc("wrap.tgt", 32'hFFFF_FFFC, 1'b0);
        check("wrap.pc8", pc_plus8, 32'h0000_0004);
        sel = 5'b00001;
        step();
        check_pc("wrap.zero", 32'h0000_0000, 1'b0);

        // Unaligned branch target passes through
        sel = 5'b10000;
        step();
        sel     = 5'b00010;
        alu_res = 32'h0000_1003;
        step();
        check_pc("unaligned", 32'h0000_1003, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
